// File: rtl/vga_timing_pkg.sv
// Shared timing constants, payload types and test-pattern colours for the
// VGA scan generator (800x600@72Hz on a 50 MHz pixel clock).
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE      = 800;
  localparam int unsigned H_FP          = 56;
  localparam int unsigned H_SYNC        = 120;
  localparam int unsigned H_BP          = 64;
  localparam int unsigned V_ACTIVE      = 600;
  localparam int unsigned V_FP          = 37;
  localparam int unsigned V_SYNC        = 6;
  localparam int unsigned V_BP          = 23;
  localparam logic        SYNC_POL      = 1'b1;
  localparam int unsigned PIXEL_LATENCY = 1;

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int unsigned H_CNT_W = 11;
  localparam int unsigned V_CNT_W = 10;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned PIXEL_W = 24;

  // Coordinate that steers the computer onto its out-of-bounds path
  localparam logic [COORD_W-1:0] OFFSCREEN_COORD = 10'h3FF;

  localparam int unsigned BAR_WIDTH = 100;

  // Control flags that travel alongside the pixel pipeline
  typedef struct packed {
    logic frame;
    logic active;
    logic vsync;
    logic hsync;
  } scan_flags_t;

  // Colour-bar table: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [PIXEL_W-1:0] bar_colour(input logic [2:0] bar);
    logic [PIXEL_W-1:0] colour;
    colour = 24'h000000;
    case (bar)
      3'd0: colour = 24'hFFFFFF;
      3'd1: colour = 24'hFFFF00;
      3'd2: colour = 24'h00FFFF;
      3'd3: colour = 24'h00FF00;
      3'd4: colour = 24'hFF00FF;
      3'd5: colour = 24'hFF0000;
      3'd6: colour = 24'h0000FF;
      default: colour = 24'h000000;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/vga_sync_delay_line.sv
// Fixed-depth shift register with synchronous reset, used to line up scan
// control flags (and the test-pattern column) with the returned pixel.
// Ports: clock, reset (sync, active-high), data (input word),
//        delayed (data from DEPTH clocks ago; DEPTH=0 is a wire).
module vga_sync_delay_line #(
  parameter int unsigned      DEPTH       = 1,
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign delayed = data;
    end else begin : g_shift
      logic [WIDTH-1:0] stages [DEPTH];

      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < int'(DEPTH); i++) stages[i] <= RESET_VALUE;
        end else begin
          stages[0] <= data;
          for (int i = 1; i < int'(DEPTH); i++) stages[i] <= stages[i-1];
        end
      end

      assign delayed = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_generator.sv
// Raster timing generator and output stage between the Mandelbrot computer
// and the VGA DAC. Owns the scan counters, requests pixels by row/col and
// re-times sync/blank so they line up with the returned pixel.
// Ports: clock, reset (sync, active-high); vga_row_out/vga_col_out pixel
//        request (10'h3FF off-screen); pixel_in {R,G,B} returned
//        PIXEL_LATENCY clocks later; vga_r/g/b, vga_hsync, vga_vsync,
//        vga_blank_n, frame_start registered DAC-side outputs.
// Optional: define VGA_TEST_PATTERN_EN to add test_pattern_sel, which swaps
//           pixel_in for eight 100-column colour bars.
module vga_scan_generator #(
  parameter int unsigned H_ACTIVE      = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP          = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC        = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP          = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE      = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP          = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC        = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP          = vga_timing_pkg::V_BP,
  parameter logic        SYNC_POL      = vga_timing_pkg::SYNC_POL,
  parameter int unsigned PIXEL_LATENCY = vga_timing_pkg::PIXEL_LATENCY
) (
  input  logic        clock,
  input  logic        reset,
  output logic [9:0]  vga_row_out,
  output logic [9:0]  vga_col_out,
  input  logic [23:0] pixel_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_pattern_sel,
`endif
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n,
  output logic        frame_start
);

  import vga_timing_pkg::*;

  localparam int unsigned H_LAST       = H_ACTIVE + H_FP + H_SYNC + H_BP - 1;
  localparam int unsigned V_LAST       = V_ACTIVE + V_FP + V_SYNC + V_BP - 1;
  localparam int unsigned H_SYNC_FIRST = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 1;
  localparam int unsigned V_SYNC_FIRST = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 1;

  localparam scan_flags_t FLAGS_RESET = '{frame: 1'b0, active: 1'b0,
                                          vsync: ~SYNC_POL, hsync: ~SYNC_POL};

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        active_raw;
  scan_flags_t flags_raw;
  scan_flags_t flags_dly;
  logic [23:0] pixel_src;

  // Scan counters: h wraps every line, v advances on each h wrap
  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == 11'(H_LAST)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == 10'(V_LAST)) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  // Pixel request straight off the counters
  assign active_raw  = (h_cnt < 11'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign vga_row_out = active_raw ? v_cnt : OFFSCREEN_COORD;
  assign vga_col_out = active_raw ? h_cnt[9:0] : OFFSCREEN_COORD;

  // Undelayed control flags for the current counter position
  always_comb begin
    flags_raw        = FLAGS_RESET;
    flags_raw.active = active_raw;
    flags_raw.frame  = (h_cnt == 11'd0) && (v_cnt == 10'd0);
    flags_raw.hsync  = (h_cnt >= 11'(H_SYNC_FIRST) && h_cnt <= 11'(H_SYNC_LAST))
                       ? SYNC_POL : ~SYNC_POL;
    flags_raw.vsync  = (v_cnt >= 10'(V_SYNC_FIRST) && v_cnt <= 10'(V_SYNC_LAST))
                       ? SYNC_POL : ~SYNC_POL;
  end

  // Match the computer's lookup latency so flags meet their pixel
  vga_sync_delay_line #(
    .DEPTH      (PIXEL_LATENCY),
    .WIDTH      ($bits(scan_flags_t)),
    .RESET_VALUE(FLAGS_RESET)
  ) u_flag_delay (
    .clock  (clock),
    .reset  (reset),
    .data   (flags_raw),
    .delayed(flags_dly)
  );

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] col_dly;

  // Column travels with the flags so bars line up with blank/sync
  vga_sync_delay_line #(
    .DEPTH      (PIXEL_LATENCY),
    .WIDTH      (10),
    .RESET_VALUE(OFFSCREEN_COORD)
  ) u_col_delay (
    .clock  (clock),
    .reset  (reset),
    .data   (vga_col_out),
    .delayed(col_dly)
  );

  assign pixel_src = test_pattern_sel
                     ? bar_colour(3'(col_dly / 10'(BAR_WIDTH)))
                     : pixel_in;
`else
  assign pixel_src = pixel_in;
`endif

  // Output register: pixel and flags leave together; blanked pixels are black
  always_ff @(posedge clock) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hsync   <= ~SYNC_POL;
      vga_vsync   <= ~SYNC_POL;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= flags_dly.active ? pixel_src : 24'h000000;
      vga_hsync   <= flags_dly.hsync;
      vga_vsync   <= flags_dly.vsync;
      vga_blank_n <= flags_dly.active;
      frame_start <= flags_dly.frame;
    end
  end

endmodule
